// File: rtl/chunked_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock.
// Optional macro CHUNKED_ADDER_SUB_EN adds a 'sub' input selecting a - b.
//
// state  | meaning
// S_IDLE | waiting for start; sum/carry hold the last result
// S_RUN  | adding slice r_idx each clock, carry rippled through r_c
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int N      = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int N_SAFE = (N < 1) ? 1 : N;
    localparam int IDX_W  = (N_SAFE > 1) ? $clog2(N_SAFE) : 1;
    localparam int BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
            $error("chunked_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
                   WIDTH, CHUNK);
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_psum;
    logic               r_c;
    logic [IDX_W-1:0]   r_idx;

    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;
    logic [BASE_W-1:0]  w_base;
    logic [CHUNK:0]     w_slice;
    logic [WIDTH-1:0]   w_psum_next;
    logic               w_last;

    // Subtraction is a + ~b + 1, so only the latched operand and initial carry differ.
    always_comb begin
        w_b_in = b;
        w_c_in = cin;
`ifdef CHUNKED_ADDER_SUB_EN
        if (sub) begin
            w_b_in = ~b;
            w_c_in = 1'b1;
        end
`endif
    end

    assign w_base  = BASE_W'(r_idx * CHUNK);
    assign w_slice = {1'b0, r_a[w_base +: CHUNK]}
                   + {1'b0, r_b[w_base +: CHUNK]}
                   + {{CHUNK{1'b0}}, r_c};
    assign w_last  = (r_idx == IDX_W'(N_SAFE - 1));

    always_comb begin
        w_psum_next                   = r_psum;
        w_psum_next[w_base +: CHUNK]  = w_slice[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_c     <= 1'b0;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            carry   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_c     <= w_c_in;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_psum <= w_psum_next;
                    r_c    <= w_slice[CHUNK];
                    if (w_last) begin
                        sum     <= w_psum_next;
                        carry   <= w_slice[CHUNK];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Randomised self-checking bench for chunked_adder (8/2 instance and a 1/1 instance).
// Subtraction checks are compiled in when CHUNKED_ADDER_SUB_EN is defined.
module tb_chunked_adder;

    localparam int W = 8;
    localparam int C = 2;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, cin, sub;
    logic [W-1:0] a, b, sum;
    logic         busy, done, carry;

    logic         start1, a1, b1, cin1, sub1;
    logic         busy1, done1, sum1, carry1;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_sum;
    logic         exp_carry;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    chunked_adder #(.WIDTH(1), .CHUNK(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .carry (carry1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outputs(input string tag, input logic eb, input logic ed);
        check({tag, ".busy"},  32'(busy),  32'(eb));
        check({tag, ".done"},  32'(done),  32'(ed));
        check({tag, ".sum"},   32'(sum),   32'(exp_sum));
        check({tag, ".carry"}, 32'(carry), 32'(exp_carry));
    endtask

    // Called at a negedge; issues a start and returns at the negedge of the done cycle.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic ts, input bit scramble, input int hold_extra);
        int unsigned full;
        start = 1'b1;
        a     = ta;
        b     = tb;
        cin   = tc;
        sub   = ts;
        if (ts) full = 32'(ta) + 32'd256 - 32'(tb);
        else    full = 32'(ta) + 32'(tb) + 32'(tc);
        @(negedge clk);
        for (int c = 1; c <= N; c++) begin
            expect_outputs($sformatf("run%0d", c), 1'b1, 1'b0);
            start = (c <= hold_extra);
            if (scramble || start) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
            end
            @(negedge clk);
        end
        exp_sum   = full[W-1:0];
        exp_carry = full[W];
        expect_outputs("done", 1'b0, 1'b1);
        start = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            expect_outputs("idle", 1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ab;
        logic [1:0] s1;
        logic       use_sub;

        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
        exp_sum = '0; exp_carry = 1'b0;
        #1;
        expect_outputs("reset", 1'b0, 1'b0);
        check("reset1.busy", 32'(busy1), 32'd0);
        check("reset1.sum",  32'(sum1),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Zero operands, exact latency
        op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        idle(1);

        // Carry out, operands scrambled while busy
        op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 0);
        idle(1);
        op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 0);
        idle(2);

        // Start held during busy is ignored, then back-to-back from the done cycle
        op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 3);
        op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 0);
        idle(1);

        // Reset in the middle of RUN
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_sum = '0; exp_carry = 1'b0;
        expect_outputs("rst_mid", 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            expect_outputs("rst_hold", 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        idle(1);
        op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        idle(1);

        // One-bit instance: half adder truth table, then full adder with random cin
        for (int i = 0; i < 8; i++) begin
            ab     = 2'(i);
            start1 = 1'b1;
            a1     = ab[1];
            b1     = ab[0];
            cin1   = (i < 4) ? 1'b0 : 1'($urandom);
            s1     = 2'(a1) + 2'(b1) + 2'(cin1);
            @(negedge clk);
            start1 = 1'b0;
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            check("w1.busy", 32'(busy1), 32'd1);
            check("w1.done_early", 32'(done1), 32'd0);
            @(negedge clk);
            check("w1.done",  32'(done1),  32'd1);
            check("w1.busy0", 32'(busy1),  32'd0);
            check("w1.sum",   32'(sum1),   32'(s1[0]));
            check("w1.carry", 32'(carry1), 32'(s1[1]));
        end

`ifdef CHUNKED_ADDER_SUB_EN
        op(8'h05, 8'h03, 1'b0, 1'b1, 1'b1, 0);
        idle(1);
        op(8'h03, 8'h05, 1'b1, 1'b1, 1'b1, 0);
        idle(1);
`endif

        // Random operations, random start holding and back-to-back issue
        for (int i = 0; i < 30; i++) begin
`ifdef CHUNKED_ADDER_SUB_EN
            use_sub = 1'($urandom);
`else
            use_sub = 1'b0;
`endif
            op(W'($urandom), W'($urandom), 1'($urandom), use_sub, 1'b1,
               int'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 0)
                idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
Parametrised multi-cycle adder and the sequential successor of the team's half-adder cell. It adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, and keeps the ripple carry in a register between slices. A start/busy/done handshake lets it sit on a simple control bus. When WIDTH == CHUNK it is a one-cycle registered adder; when WIDTH = 1 it is a registered half/full adder.

Parameters:
WIDTH, 8, operand and sum width in bits (≥1)
CHUNK, 2, bits added per cycle; WIDTH % CHUNK must be 0 (elaboration-time $error otherwise)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new addition; sampled on a rising clk edge
a  input  WIDTH  operand A; sampled only on an accepted start
b  input  WIDTH  operand B; sampled only on an accepted start
cin  input  1  carry-in; sampled only on an accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse; sum and carry are valid from this cycle onward
sum  output  WIDTH  result bits, held until the next completion
carry  output  1  carry-out of bit WIDTH-1, held with sum

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed): state=IDLE, busy=0, done=0, sum=0, carry=0, slice index=0, carry register=0, operand registers=0.
- States: IDLE and RUN. N = WIDTH/CHUNK.
- IDLE: start=1 at an edge is an accepted start. It latches a, b, cin, clears the slice index, enters RUN and sets busy=1.
- RUN: each edge adds slice k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of a and b plus the carry register. The CHUNK-bit result goes into the partial-sum register, the slice carry-out goes into the carry register, and k increments.
- After the N-th RUN edge: sum ← the full partial sum, carry ← the final carry, done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: an accepted start at edge E0 gives done high in the cycle after edge E0+N. busy is high in the N cycles between those edges.
- Outputs: sum and carry change only on the done edge. They are not disturbed during RUN and hold their previous result.
- start while busy=1 is ignored: no latch, no error, and the current operation is unaffected.
- start=1 in the done cycle: busy is already 0, so the start is accepted and back-to-back operations run with no gap.
- a, b and cin may change freely while busy=1. Only the values latched at acceptance are used.
- Reset mid-RUN aborts the operation. No done is produced and all outputs go to their reset values.
- Arithmetic: {carry, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow is lost.

Optional Feature:
Macro CHUNKED_ADDER_SUB_EN.
- Defined: adds port sub (input, 1), sampled with the operands on an accepted start.
  - sub=1: the latched operand is ~b, the initial carry is forced to 1, cin is ignored, so the result is a − b.
  - carry=1 means no borrow (a ≥ b, unsigned).
  - sub=0 behaves exactly as the base adder.
- Undefined: the sub port does not exist; the block is addition only. Timing is identical in both builds.

Test Plan:
1. WIDTH=8, CHUNK=2: reset, then start with a=0x00, b=0x00, cin=0 → busy high for 4 cycles, done pulses once, sum=0x00, carry=0.
2. Start with a=0xFF, b=0x01, cin=0 → sum=0x00, carry=1. Then a=0xA5, b=0x5A, cin=1 → sum=0x00, carry=1. Change a and b during busy with no effect on either result.
3. Start with a=0x12, b=0x34 and hold start high for 3 more cycles with other operands → the extra starts are ignored. Exactly one done, with sum=0x46, carry=0. Drive start=1 in the done cycle with a=0x80, b=0x80 → the next done follows after exactly 4 busy cycles, sum=0x00, carry=1.
4. Start with a=0x0F, b=0x01, then pull rst_n low 2 cycles into RUN → busy, done, sum and carry go to 0 immediately with no done pulse. A fresh start then completes normally: a=0x0F, b=0x01 → sum=0x10.
5. WIDTH=1, CHUNK=1, cin=0: sweep (a,b) over 00, 01, 10, 11 → (sum,carry) = 0/0, 1/0, 1/0, 0/1. Each result appears 1 cycle after acceptance, matching the half-adder truth table.
6. With CHUNKED_ADDER_SUB_EN and WIDTH=8, CHUNK=2: sub=1, a=0x05, b=0x03 → sum=0x02, carry=1. sub=1, a=0x03, b=0x05 → sum=0xFE, carry=0. Latency is 4 cycles in both cases.
